// File: rtl/cla_add32_pipe.sv
// Two-stage pipelined carry-lookahead adder with valid/ready flow control.
// Optional signed-overflow output enabled by defining CLA_ADD32_OVF_EN.
module cla_add32_pipe #(
  parameter int GROUPS = 8,
  localparam int W = 4 * GROUPS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c0,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] s,
  output logic         co,
  output logic         gp,
  output logic         gg,
  output logic         ovf
);

  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high; valid holds with stable data until taken, ready may depend on
  // downstream ready but never on valid.
  logic s1_valid;
  logic s2_take;
  logic s1_adv;
  logic accept;

  assign s2_take  = !out_valid || out_ready;
  assign s1_adv   = s1_valid && s2_take;
  assign in_ready = !s1_valid || s2_take;
  assign accept   = in_valid && in_ready;

  // Stage 1 combinational: bit and group propagate/generate
  logic [W-1:0]      p_d;
  logic [W-1:0]      g_d;
  logic [GROUPS-1:0] grp_p_d;
  logic [GROUPS-1:0] grp_g_d;

  always_comb begin
    p_d     = a ^ b;
    g_d     = a & b;
    grp_p_d = '0;
    grp_g_d = '0;
    for (int k = 0; k < GROUPS; k++) begin
      grp_p_d[k] = p_d[4*k+3] & p_d[4*k+2] & p_d[4*k+1] & p_d[4*k];
      grp_g_d[k] = g_d[4*k+3]
                 | (p_d[4*k+3] & g_d[4*k+2])
                 | (p_d[4*k+3] & p_d[4*k+2] & g_d[4*k+1])
                 | (p_d[4*k+3] & p_d[4*k+2] & p_d[4*k+1] & g_d[4*k]);
    end
  end

  logic [W-1:0]      s1_p;
  logic [W-1:0]      s1_g;
  logic [GROUPS-1:0] s1_grp_p;
  logic [GROUPS-1:0] s1_grp_g;
  logic              s1_c0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_p     <= '0;
      s1_g     <= '0;
      s1_grp_p <= '0;
      s1_grp_g <= '0;
      s1_c0    <= 1'b0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        s1_p     <= p_d;
        s1_g     <= g_d;
        s1_grp_p <= grp_p_d;
        s1_grp_g <= grp_g_d;
        s1_c0    <= c0;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end
    end
  end

`ifdef CLA_ADD32_OVF_EN
  logic s1_a_msb;
  logic s1_b_msb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_a_msb <= 1'b0;
      s1_b_msb <= 1'b0;
    end else if (accept) begin
      s1_a_msb <= a[W-1];
      s1_b_msb <= b[W-1];
    end
  end
`endif

  // Group carries as a flat sum of products: each term is one generate
  // (or the carry-in) ANDed with every propagate above it.
  logic [GROUPS:0] grp_c;
  logic            term;

  always_comb begin
    grp_c    = '0;
    grp_c[0] = s1_c0;
    term     = 1'b0;
    for (int k = 0; k < GROUPS; k++) begin
      for (int j = -1; j <= k; j++) begin
        term = (j < 0) ? s1_c0 : s1_grp_g[j];
        for (int m = j + 1; m <= k; m++) begin
          term = term & s1_grp_p[m];
        end
        grp_c[k+1] = grp_c[k+1] | term;
      end
    end
  end

  // Intra-group carries use the same flattened form, seeded by the group carry
  logic [W-1:0] bit_c;
  logic         bterm;

  always_comb begin
    bit_c = '0;
    bterm = 1'b0;
    for (int k = 0; k < GROUPS; k++) begin
      for (int t = 0; t < 4; t++) begin
        for (int j = -1; j < t; j++) begin
          bterm = (j < 0) ? grp_c[k] : s1_g[4*k+j];
          for (int m = j + 1; m < t; m++) begin
            bterm = bterm & s1_p[4*k+m];
          end
          bit_c[4*k+t] = bit_c[4*k+t] | bterm;
        end
      end
    end
  end

  logic [W-1:0] s_d;
  logic         blk_p_d;
  logic         blk_g_d;
  logic         gterm;
  logic         ovf_d;

  always_comb begin
    s_d     = s1_p ^ bit_c;
    blk_p_d = &s1_grp_p;
    blk_g_d = 1'b0;
    gterm   = 1'b0;
    for (int j = 0; j < GROUPS; j++) begin
      gterm = s1_grp_g[j];
      for (int m = j + 1; m < GROUPS; m++) begin
        gterm = gterm & s1_grp_p[m];
      end
      blk_g_d = blk_g_d | gterm;
    end
  end

`ifdef CLA_ADD32_OVF_EN
  assign ovf_d = (s1_a_msb == s1_b_msb) && (s_d[W-1] != s1_a_msb);
`else
  assign ovf_d = 1'b0;
`endif

  // Stage 2: results held while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      s         <= '0;
      co        <= 1'b0;
      gp        <= 1'b0;
      gg        <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      if (s1_adv) begin
        out_valid <= 1'b1;
        s         <= s_d;
        co        <= grp_c[GROUPS];
        gp        <= blk_p_d;
        gg        <= blk_g_d;
        ovf       <= ovf_d;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cla_add32_pipe.sv
// Self-checking bench for cla_add32_pipe: directed vectors, nibble sweep,
// backpressure, mid-stream reset and randomized traffic against an arithmetic model.
module tb_cla_add32_pipe;

  localparam int W = 32;
`ifdef CLA_ADD32_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c0;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] s;
  logic         co;
  logic         gp;
  logic         gg;
  logic         ovf;

  cla_add32_pipe #(.GROUPS(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c0        (c0),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .co        (co),
    .gp        (gp),
    .gg        (gg),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pops = 0;
  int accepts = 0;
  logic rnd_bp = 1'b0;
  logic [W+3:0] exp_q[$];

  task automatic check(input string tag, input logic [W+3:0] got, input logic [W+3:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: {ovf, gg, gp, co, s} from plain integer addition
  function automatic logic [W+3:0] model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
    logic [W:0] sum;
    logic [W:0] sum_nc;
    logic       m_gp;
    logic       m_ovf;
    sum    = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, cv};
    sum_nc = {1'b0, av} + {1'b0, bv};
    m_gp   = ((av ^ bv) == {W{1'b1}});
    m_ovf  = OVF_ON && (av[W-1] == bv[W-1]) && (sum[W-1] != av[W-1]);
    return {m_ovf, sum_nc[W], m_gp, sum[W], sum[W-1:0]};
  endfunction

  function automatic logic [W+3:0] observed();
    return {ovf, gg, gp, co, s};
  endfunction

  // Scoreboard: push on accept, pop/compare on output transfer, hold check on stall
  logic         stalled = 1'b0;
  logic [W+3:0] held;

  always @(negedge clk) begin
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
      if (stalled && out_valid)
        check("stall_hold", observed(), held);
      if (out_valid && out_ready) begin
        pops++;
        if (exp_q.size() == 0)
          check("unexpected_result", observed(), {(W+4){1'bx}});
        else
          check("sb_result", observed(), exp_q.pop_front());
      end
      if (in_valid && in_ready) begin
        accepts++;
        exp_q.push_back(model(a, b, c0));
      end
      stalled = out_valid && !out_ready;
      held    = observed();
    end
  end

  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
    logic ok;
    ok = 1'b0;
    a = av; b = bv; c0 = cv; in_valid = 1'b1;
    for (int n = 0; n < 200 && !ok; n++) begin
      if (rnd_bp) out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) check("send_timeout", 36'd0, 36'd1);
  endtask

  task automatic drain();
    rnd_bp = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 100 && (exp_q.size() != 0 || out_valid); n++) begin
      @(posedge clk);
      #1;
    end
    check("drain_empty", 36'(exp_q.size()), 36'd0);
    check("drain_out_valid", {35'd0, out_valid}, 36'd0);
  endtask

  // Send with consumer stalled, verify latency and constant expectation, then drain
  task automatic send_expect(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                             input logic cv, input logic [W+3:0] exp);
    int waited;
    out_ready = 1'b0;
    send(av, bv, cv);
    check({tag, "_not_early"}, {35'd0, out_valid}, 36'd0);
    waited = 0;
    while (!out_valid && waited < 4) begin
      @(posedge clk);
      #1;
      waited++;
    end
    check({tag, "_latency_ok"}, {35'd0, (waited >= 1 && waited <= 2)}, 36'd1);
    check(tag, observed(), exp);
    drain();
  endtask

  initial begin
    int idx;
    int p0;
    int a0;
    logic acc;
    logic [8:0] sw;

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; c0 = 1'b0; out_ready = 1'b0;
    #12;
    check("rst_out_valid", {35'd0, out_valid}, 36'd0);
    check("rst_outputs", observed(), 36'd0);
    check("rst_in_ready", {35'd0, in_ready}, 36'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", {35'd0, in_ready}, 36'd1);

    send_expect("ff_plus_1", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, {1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0000});
    send_expect("max_pos_plus_1", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, {OVF_ON, 1'b0, 1'b0, 1'b0, 32'h8000_0000});
    send_expect("nibble_carry_in", 32'h0000_000F, 32'h0000_0000, 1'b1, {1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0010});
    send_expect("alt_pattern", 32'h5555_5555, 32'hAAAA_AAAA, 1'b1, {1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0000});

    // Nibble sweep streamed back-to-back at full rate
    out_ready = 1'b1;
    a0 = accepts;
    for (int i = 0; i < 512; i++) begin
      sw = 9'(i);
      a = {28'd0, sw[8:5]}; b = {28'd0, sw[4:1]}; c0 = sw[0]; in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("sweep_full_rate", 36'(accepts - a0), 36'd512);
    drain();

    // Backpressure: consumer stalled while four sums are offered
    out_ready = 1'b0;
    p0 = pops;
    idx = 0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      a = 32'(idx + 1); b = 32'(idx + 1); c0 = 1'b0; in_valid = (idx < 4);
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
    end
    in_valid = 1'b0;
    check("bp_accepts", 36'(idx), 36'd2);
    check("bp_in_ready_low", {35'd0, in_ready}, 36'd0);
    check("bp_out_valid", {35'd0, out_valid}, 36'd1);
    check("bp_head_held", observed(), {4'b0000, 32'd2});
    out_ready = 1'b1;
    while (idx < 4) begin
      send(32'(idx + 1), 32'(idx + 1), 1'b0);
      idx++;
    end
    drain();
    check("bp_pop_count", 36'(pops - p0), 36'd4);

    // Reset with both stages full
    out_ready = 1'b0;
    send(32'd100, 32'd200, 1'b0);
    send(32'd300, 32'd400, 1'b0);
    check("full_in_ready_low", {35'd0, in_ready}, 36'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {35'd0, out_valid}, 36'd0);
    check("midrst_outputs", observed(), 36'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst_in_ready", {35'd0, in_ready}, 36'd1);
    p0 = pops;
    send_expect("after_reset_9_9", 32'd9, 32'd9, 1'b0, {4'b0000, 32'd18});
    check("after_reset_single", 36'(pops - p0), 36'd1);

    // Randomized traffic with random consumer stalls and idle gaps
    rnd_bp = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send($urandom, $urandom, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 7) == 0) begin
        out_ready = ($urandom_range(0, 1) != 0);
        @(posedge clk); #1;
      end
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
